// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - shared register map, control bits and FSM encoding for the buzzer tone generator
//   No ports. Imported by buzzer_tone_gen and buzzer_half_divider.
package buzzer_pkg;

    localparam logic [1:0] ADDR_HALF_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_DURATION    = 2'd1;
    localparam logic [1:0] ADDR_CONTROL     = 2'd2;
    localparam logic [1:0] ADDR_STATUS      = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/buzzer_half_divider.sv
// rtl/buzzer_half_divider.sv - loadable half-period down-counter with terminal-count pulse
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : force the counter to value (takes priority over counting)
//   enable     : count while a tone is running
//   value      : load / reload value (half period minus one)
//   tc         : high during the last cycle of a half period
module buzzer_half_divider
    import buzzer_pkg::*;
#(
    parameter int HP_WIDTH = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                enable,
    input  logic [HP_WIDTH-1:0] value,
    output logic                tc
);

    logic [HP_WIDTH-1:0] cnt_q;
    logic [HP_WIDTH-1:0] cnt_d;

    assign tc = enable && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (enable) begin
            // Reload on terminal count so the next half period starts seamlessly.
            cnt_d = (cnt_q == '0) ? value : cnt_q - HP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buzzer_tone_gen.sv
// rtl/buzzer_tone_gen.sv - Avalon-MM slave generating a timed square wave on the buzzer pin
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : register write port (0 HALF_PERIOD, 1 DURATION, 2 CONTROL, 3 STATUS)
//   readdata              : registered read data, one cycle latency
//   buzzer_out            : square-wave drive
//   tone_done             : one-cycle pulse when a tone finishes on its own
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int   HP_WIDTH   = 24,
    parameter int   DUR_WIDTH  = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        buzzer_out,
    output logic        tone_done
);

    logic [HP_WIDTH-1:0]  hp_q, hp_d;
    logic [DUR_WIDTH-1:0] dur_q, dur_d;
    logic [HP_WIDTH-1:0]  hp_work_q, hp_work_d;
    logic [DUR_WIDTH-1:0] dur_work_q, dur_work_d;
    logic [DUR_WIDTH-1:0] period_q, period_d;
    logic [1:0]           state_q, state_d;
    logic                 done_sticky_q, done_sticky_d;
    logic                 buzzer_q, buzzer_d;
    logic                 tone_done_q, tone_done_d;
    logic [31:0]          readdata_q, readdata_d;

    logic                 wr_en;
    logic                 start;
    logic                 stop;
    logic                 busy;
    logic [HP_WIDTH-1:0]  hp_clamped;
    logic [HP_WIDTH-1:0]  div_value;
    logic                 div_tc;
    logic                 unused_wdata;

    assign wr_en = chipselect && !write_n;
    // Stop dominates a simultaneous start.
    assign stop  = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_STOP];
    assign start = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_START] && !writedata[CTRL_STOP];
    assign busy  = (state_q != ST_IDLE);

    // A half period shorter than 2 cycles cannot be counted as hp-1 down to 0 usefully.
    assign hp_clamped = (hp_q < HP_WIDTH'(2)) ? HP_WIDTH'(2) : hp_q;
    assign div_value  = start ? (hp_clamped - HP_WIDTH'(1)) : (hp_work_q - HP_WIDTH'(1));

    assign unused_wdata = ^writedata;

    buzzer_half_divider #(
        .HP_WIDTH (HP_WIDTH)
    ) u_half_divider (
        .clk    (clk),
        .rst_n  (reset_n),
        .load   (start),
        .enable (busy),
        .value  (div_value),
        .tc     (div_tc)
    );

    always_comb begin
        hp_d          = hp_q;
        dur_d         = dur_q;
        hp_work_d     = hp_work_q;
        dur_work_d    = dur_work_q;
        period_d      = period_q;
        state_d       = state_q;
        done_sticky_d = done_sticky_q;
        buzzer_d      = buzzer_q;
        tone_done_d   = 1'b0;

        if (wr_en && (address == ADDR_HALF_PERIOD)) begin
            hp_d = writedata[HP_WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_DURATION)) begin
            dur_d = writedata[DUR_WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_STATUS)) begin
            done_sticky_d = 1'b0;
        end

        if (stop) begin
            state_d  = ST_IDLE;
            buzzer_d = IDLE_LEVEL;
        end else if (start) begin
            state_d    = ST_HIGH;
            buzzer_d   = 1'b1;
            hp_work_d  = hp_clamped;
            dur_work_d = dur_q;
            period_d   = DUR_WIDTH'(1);
        end else begin
            case (state_q)
                ST_HIGH: begin
                    if (div_tc) begin
                        state_d  = ST_LOW;
                        buzzer_d = 1'b0;
                    end
                end
                ST_LOW: begin
                    if (div_tc) begin
                        if ((dur_work_q != '0) && (period_q == dur_work_q)) begin
                            state_d       = ST_IDLE;
                            buzzer_d      = IDLE_LEVEL;
                            tone_done_d   = 1'b1;
                            // Completion beats a same-cycle STATUS clear.
                            done_sticky_d = 1'b1;
                        end else begin
                            state_d  = ST_HIGH;
                            buzzer_d = 1'b1;
                            period_d = period_q + DUR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    buzzer_d = IDLE_LEVEL;
                end
            endcase
        end

        readdata_d = 32'd0;
        case (address)
            ADDR_HALF_PERIOD: readdata_d = 32'(hp_q);
            ADDR_DURATION:    readdata_d = 32'(dur_q);
            ADDR_CONTROL:     readdata_d = {31'd0, busy};
            default:          readdata_d = {31'd0, done_sticky_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp_q          <= '0;
            dur_q         <= '0;
            hp_work_q     <= '0;
            dur_work_q    <= '0;
            period_q      <= '0;
            state_q       <= ST_IDLE;
            done_sticky_q <= 1'b0;
            buzzer_q      <= IDLE_LEVEL;
            tone_done_q   <= 1'b0;
            readdata_q    <= 32'd0;
        end else begin
            hp_q          <= hp_d;
            dur_q         <= dur_d;
            hp_work_q     <= hp_work_d;
            dur_work_q    <= dur_work_d;
            period_q      <= period_d;
            state_q       <= state_d;
            done_sticky_q <= done_sticky_d;
            buzzer_q      <= buzzer_d;
            tone_done_q   <= tone_done_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata   = readdata_q;
    assign buzzer_out = buzzer_q;
    assign tone_done  = tone_done_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// tb/tb_buzzer_tone_gen.sv - directed self-checking bench for buzzer_tone_gen
module tb_buzzer_tone_gen;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        buzzer_out;
    logic        tone_done;

    int n_checks;
    int n_errors;

    buzzer_tone_gen #(
        .HP_WIDTH   (24),
        .DUR_WIDTH  (16),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .buzzer_out (buzzer_out),
        .tone_done  (tone_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = en;
        write_n    = !en;
    endtask

    logic [31:0] rd;
    logic        exp_bz;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_buzzer", {31'd0, buzzer_out}, 32'd0);
        check("rst_done", {31'd0, tone_done}, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("rst_read%0d", a), rd, 32'd0);
        end

        // HALF_PERIOD=4, DURATION=3; CONTROL address stays selected, so readdata tracks busy.
        bus_write(2'd0, 32'd4);
        bus_write(2'd1, 32'd3);
        bus_read(2'd0, rd);
        check("hp_readback", rd, 32'd4);
        bus_read(2'd1, rd);
        check("dur_readback", rd, 32'd3);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 27; k++) begin
            exp_bz = (k <= 24) && ((((k - 1) / 4) % 2) == 0);
            check($sformatf("t1_bz_k%0d", k), {31'd0, buzzer_out}, {31'd0, exp_bz});
            check($sformatf("t1_done_k%0d", k), {31'd0, tone_done}, (k == 25) ? 32'd1 : 32'd0);
            check($sformatf("t1_busy_k%0d", k), readdata, (k >= 2 && k <= 25) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        bus_read(2'd2, rd);
        check("t1_busy_after", rd, 32'd0);
        bus_read(2'd3, rd);
        check("t1_status_set", rd, 32'd1);
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, rd);
        check("t1_status_clr", rd, 32'd0);

        // HALF_PERIOD=1 clamps to 2.
        bus_write(2'd0, 32'd1);
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("t2_bz_k%0d", k), {31'd0, buzzer_out}, (k <= 2) ? 32'd1 : 32'd0);
            check($sformatf("t2_done_k%0d", k), {31'd0, tone_done}, (k == 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        bus_write(2'd3, 32'd0);

        // Continuous tone, then stop.
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 100; k++) begin
            exp_bz = ((((k - 1) / 3) % 2) == 0);
            check($sformatf("t3_bz_k%0d", k), {31'd0, buzzer_out}, {31'd0, exp_bz});
            check($sformatf("t3_done_k%0d", k), {31'd0, tone_done}, 32'd0);
            @(negedge clk);
        end
        bus_write(2'd2, 32'd2);
        check("t3_bz_after_stop", {31'd0, buzzer_out}, 32'd0);
        check("t3_done_after_stop", {31'd0, tone_done}, 32'd0);
        bus_read(2'd2, rd);
        check("t3_busy_after_stop", rd, 32'd0);
        bus_read(2'd3, rd);
        check("t3_status", rd, 32'd0);

        // Working copies survive a register write; restart uses the new value.
        bus_write(2'd0, 32'd10);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 24; k++) begin
            if (k <= 10)      exp_bz = 1'b1;
            else if (k <= 12) exp_bz = 1'b0;
            else if (k <= 20) exp_bz = ((((k - 13) / 2) % 2) == 0);
            else              exp_bz = 1'b0;
            check($sformatf("t4_bz_k%0d", k), {31'd0, buzzer_out}, {31'd0, exp_bz});
            check($sformatf("t4_done_k%0d", k), {31'd0, tone_done}, (k == 21) ? 32'd1 : 32'd0);
            if (k == 5)       drive(1'b1, 2'd0, 32'd2);
            else if (k == 12) drive(1'b1, 2'd2, 32'd1);
            else              drive(1'b0, address, writedata);
            @(negedge clk);
        end
        bus_write(2'd3, 32'd0);

        // STATUS clear coinciding with completion: set wins.
        bus_write(2'd0, 32'd2);
        bus_write(2'd1, 32'd1);
        bus_write(2'd2, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("t5_done_k%0d", k), {31'd0, tone_done}, (k == 5) ? 32'd1 : 32'd0);
            if (k == 4) drive(1'b1, 2'd3, 32'd0);
            else        drive(1'b0, address, writedata);
            @(negedge clk);
        end
        bus_read(2'd3, rd);
        check("t5_status_set_wins", rd, 32'd1);
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, rd);
        check("t5_status_clr", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_gen.md
Name: buzzer_tone_gen

Overview:
Avalon-MM slave that drives the board buzzer pin with a software-programmed square wave for a programmed number of periods. It sits directly upstream of the buzzer input PIO. Its tone_done pulse feeds that PIO's in_port, so the PIO's rising-edge capture flags tone completion to the Nios II CPU. Register reads and writes follow the team's PIO slave timing: zero wait states and registered readdata.

Parameters:
HP_WIDTH, 24, width of half-period count in clk cycles
DUR_WIDTH, 16, width of duration count in full tone periods
IDLE_LEVEL, 0, buzzer_out level while idle

Ports:
clk  input  1  system clock
reset_n  input  1  reset; one clock, asynchronous active-low reset (reset_n), all flops clear on negedge reset_n
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
buzzer_out  output  1  square-wave drive to buzzer pin
tone_done  output  1  one-cycle pulse on natural tone completion

Behaviour:
- Register map. A write occurs when chipselect && !write_n.
  - addr 0 HALF_PERIOD: R/W, bits [HP_WIDTH-1:0]. Values below 2 are treated as 2 when latched.
  - addr 1 DURATION: R/W, bits [DUR_WIDTH-1:0], counted in full periods. 0 means continuous until stop.
  - addr 2 CONTROL: write bit0=start, bit1=stop. Read bit0=busy.
  - addr 3 STATUS: bit0=done_sticky. Any write clears it.
- readdata:
  - Registered every cycle, independent of chipselect; 1-cycle read latency.
  - Unused bits read 0.
  - Reset value 0.
- Reset values:
  - buzzer_out=IDLE_LEVEL, tone_done=0, readdata=0.
  - HALF_PERIOD=0, DURATION=0, done_sticky=0, state=IDLE.
- State machine: IDLE, HIGH, LOW.
  - IDLE -> HIGH on start write accepted at edge N.
    - HALF_PERIOD (clamped) and DURATION are latched into working copies.
    - buzzer_out=1 from cycle N+1.
  - HIGH lasts exactly hp cycles, then -> LOW with buzzer_out=0.
  - LOW lasts hp cycles. Then:
    - if DURATION≠0 and this was period number DURATION -> IDLE;
    - otherwise -> HIGH and the period counter increments.
  - On the LOW->IDLE transition:
    - buzzer_out=IDLE_LEVEL;
    - tone_done=1 for exactly that one cycle;
    - done_sticky set.
- Working copies: writes to HALF_PERIOD or DURATION during a tone do not affect the running tone; they take effect at the next start.
- Stop:
  - Stop write in HIGH or LOW -> IDLE on the next edge, buzzer_out=IDLE_LEVEL.
  - No tone_done pulse; done_sticky unchanged.
- Start while busy: restarts the tone from HIGH with freshly latched values. No tone_done for the aborted tone.
- Start and stop in the same write: stop wins.
- A done_sticky clear in the same cycle as completion: set wins.
- busy = (state≠IDLE). It reads 1 in the read issued the cycle after a start write.
- Counters:
  - Half-period counter counts down from hp-1 to 0, then reloads.
  - Period counter is DUR_WIDTH bits. With DURATION=0 it never terminates and the period counter does not wrap-trigger.
- Reset asserted mid-tone: immediate IDLE, all outputs to reset values.

Decomposition:
- Shared package buzzer_pkg:
  - register address constants ADDR_HALF_PERIOD=0, ADDR_DURATION=1, ADDR_CONTROL=2, ADDR_STATUS=3;
  - control bit indices CTRL_START=0, CTRL_STOP=1;
  - state encoding IDLE/HIGH/LOW.
- One sub-module, buzzer_half_divider:
  - loadable HP_WIDTH down-counter;
  - inputs load, value;
  - output terminal-count pulse.
  - The top keeps the register file, FSM, period counter and read mux.

Test Plan:
- Reset -> readdata=0, buzzer_out=0, tone_done=0. A read of each address returns 0.
- HALF_PERIOD=4, DURATION=3, start at edge N:
  - buzzer_out high N+1..N+4, low N+5..N+8, repeated 3 times;
  - tone_done=1 only in cycle N+25;
  - STATUS reads 1;
  - CONTROL busy reads 0 after N+25.
- HALF_PERIOD=1, DURATION=1 -> clamped to 2: high 2 cycles, low 2 cycles, tone_done at N+5.
- DURATION=0, HALF_PERIOD=3, start, run 100 cycles, then write stop:
  - continuous 6-cycle period;
  - buzzer_out=0 the cycle after stop;
  - no tone_done;
  - STATUS stays 0.
- HALF_PERIOD=10, DURATION=2, start, write HALF_PERIOD=2 at cycle N+5, then issue start at N+12:
  - the first tone is unaffected until N+12;
  - the restart uses hp=2;
  - only one tone_done, at the end of the second tone.
- Completion cycle coincides with a STATUS write -> done_sticky=1. A separate STATUS write afterwards clears it to 0.
